// File: rtl/frame_check.sv
// -----------------------------------------------------------------------------
// frame_check
// Serial frame checker. Bits arrive already sampled (sampled_bit qualified by a
// one-cycle bit_valid strobe). A strobe tagged with frame_start opens a frame.
// The frame then carries DATA_LEN data bits LSB-first, an optional parity bit
// and one or two stop bits. The block delivers the data with parity and stop
// error flags, and keeps saturating counts of both error kinds.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   sampled_bit     serial bit value, qualified by bit_valid
//   bit_valid       one-cycle strobe; only strobed cycles advance the FSM
//   frame_start     strobed bit is a start bit (aborts any frame in progress)
//   DATA_LEN        data bits per frame (0 or > DATA_WIDTH means DATA_WIDTH)
//   PAR_EN, PAR_TYP parity present; 00 even, 01 odd, 10 mark, 11 space
//   STOP_BITS       0 = one stop bit, 1 = two stop bits
//   cnt_clr         synchronous clear of both error counters
//   P_DATA          received data, right-aligned, held between frames
//   data_valid      one-cycle pulse, the cycle after the last stop strobe
//   par_err/stp_err frame error flags, valid with data_valid
//   strt_err        one-cycle pulse when a start strobe carries a 1
//   par_err_cnt/stp_err_cnt  saturating error counters
// -----------------------------------------------------------------------------
module frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              sampled_bit,
   input  logic                              bit_valid,
   input  logic                              frame_start,
   input  logic [$clog2(DATA_WIDTH+1)-1:0]   DATA_LEN,
   input  logic                              PAR_EN,
   input  logic [1:0]                        PAR_TYP,
   input  logic                              STOP_BITS,
   input  logic                              cnt_clr,
   output logic [DATA_WIDTH-1:0]             P_DATA,
   output logic                              data_valid,
   output logic                              par_err,
   output logic                              stp_err,
   output logic                              strt_err,
   output logic [CNT_WIDTH-1:0]              par_err_cnt,
   output logic [CNT_WIDTH-1:0]              stp_err_cnt
);

   localparam int              LW       = $clog2(DATA_WIDTH + 1);
   localparam logic [LW-1:0]   FULL_LEN = LW'(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   shadow;
   logic [LW-1:0]           bit_cnt;
   logic [LW-1:0]           len_q;
   logic                    run_par;
   logic                    par_en_q;
   logic [1:0]              par_typ_q;
   logic                    stop_bits_q;
   logic                    par_err_acc;
   logic                    stp_err_acc;

   logic [LW-1:0]           len_eff;
   logic                    exp_par;
   logic                    stp_err_now;

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      len_eff = DATA_LEN;
      if (DATA_LEN == '0 || DATA_LEN > FULL_LEN)
         len_eff = FULL_LEN;

      exp_par = 1'b0;
      case (par_typ_q)
         2'b00:   exp_par = run_par;
         2'b01:   exp_par = ~run_par;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase

      // Stop errors accumulate over both stop bits.
      stp_err_now = stp_err_acc | ~sampled_bit;
   end

   // NOTE: state registers use non-blocking assignments so that every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state       <= IDLE;
         shadow      <= '0;
         bit_cnt     <= '0;
         len_q       <= '0;
         run_par     <= 1'b0;
         par_en_q    <= 1'b0;
         par_typ_q   <= 2'b00;
         stop_bits_q <= 1'b0;
         par_err_acc <= 1'b0;
         stp_err_acc <= 1'b0;
         P_DATA      <= '0;
         data_valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_err    <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         strt_err   <= 1'b0;
         if (bit_valid) begin
            if (frame_start) begin
               // A start strobe wins in any state. A frame in progress is
               // dropped silently.
               if (sampled_bit) begin
                  strt_err <= 1'b1;
                  state    <= IDLE;
               end else begin
                  state       <= DATA;
                  shadow      <= '0;
                  bit_cnt     <= '0;
                  run_par     <= 1'b0;
                  par_err_acc <= 1'b0;
                  stp_err_acc <= 1'b0;
                  len_q       <= len_eff;
                  par_en_q    <= PAR_EN;
                  par_typ_q   <= PAR_TYP;
                  stop_bits_q <= STOP_BITS;
               end
            end else begin
               case (state)
                  IDLE: ;
                  DATA: begin
                     // The shadow register is cleared at the start bit. ORing
                     // each bit into place leaves the data right-aligned for
                     // any length.
                     shadow  <= shadow | (DATA_WIDTH'(sampled_bit) << bit_cnt);
                     run_par <= run_par ^ sampled_bit;
                     bit_cnt <= bit_cnt + LW'(1);
                     if (bit_cnt + LW'(1) == len_q)
                        state <= par_en_q ? PARITY : STOP1;
                  end
                  PARITY: begin
                     par_err_acc <= exp_par ^ sampled_bit;
                     state       <= STOP1;
                  end
                  STOP1: begin
                     if (stop_bits_q) begin
                        stp_err_acc <= stp_err_now;
                        state       <= STOP2;
                     end else begin
                        state      <= IDLE;
                        data_valid <= 1'b1;
                        P_DATA     <= shadow;
                        par_err    <= par_err_acc;
                        stp_err    <= stp_err_now;
                     end
                  end
                  STOP2: begin
                     state      <= IDLE;
                     data_valid <= 1'b1;
                     P_DATA     <= shadow;
                     par_err    <= par_err_acc;
                     stp_err    <= stp_err_now;
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   // Counters advance during the data_valid cycle. A clear always wins.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         par_err_cnt <= '0;
         stp_err_cnt <= '0;
      end else if (cnt_clr) begin
         par_err_cnt <= '0;
         stp_err_cnt <= '0;
      end else if (data_valid) begin
         if (par_err && par_err_cnt != '1)
            par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
         if (stp_err && stp_err_cnt != '1)
            stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_frame_check.sv
// -----------------------------------------------------------------------------
// tb_frame_check
// Self-checking bench for frame_check. Two instances share all inputs: one
// uses 8-bit counters and one uses 2-bit counters, so that saturation is
// exercised. Frames are described at bit level by the bench. The expected
// data, flags and counts come from the frame description itself, not from
// any model of the FSM.
// -----------------------------------------------------------------------------
module tb_frame_check;

   localparam int DW = 8;
   localparam int LW = 4;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            sampled_bit, bit_valid, frame_start;
   logic [LW-1:0]   DATA_LEN;
   logic            PAR_EN;
   logic [1:0]      PAR_TYP;
   logic            STOP_BITS;
   logic            cnt_clr;

   logic [DW-1:0]   p_data8, p_data2;
   logic            dv8, dv2, perr8, perr2, serr8, serr2, strt8, strt2;
   logic [7:0]      pcnt8, scnt8;
   logic [1:0]      pcnt2, scnt2;

   int n_checks = 0;
   int n_pass   = 0;
   int dv_cnt   = 0;
   int par_m    = 0;
   int stp_m    = 0;
   logic [DW-1:0] last_data = '0;

   always #5 CLK = ~CLK;

   frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) dut8 (
      .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .bit_valid(bit_valid),
      .frame_start(frame_start), .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .STOP_BITS(STOP_BITS), .cnt_clr(cnt_clr),
      .P_DATA(p_data8), .data_valid(dv8), .par_err(perr8), .stp_err(serr8),
      .strt_err(strt8), .par_err_cnt(pcnt8), .stp_err_cnt(scnt8));

   frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
      .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .bit_valid(bit_valid),
      .frame_start(frame_start), .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN),
      .PAR_TYP(PAR_TYP), .STOP_BITS(STOP_BITS), .cnt_clr(cnt_clr),
      .P_DATA(p_data2), .data_valid(dv2), .par_err(perr2), .stp_err(serr2),
      .strt_err(strt2), .par_err_cnt(pcnt2), .stp_err_cnt(scnt2));

   // Count every data_valid pulse so that dropped or extra frames show up.
   always @(posedge CLK) begin
      #1;
      if (dv8) dv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic int sat(input int v, input int w);
      int top = (1 << w) - 1;
      return (v > top) ? top : v;
   endfunction

   task automatic check_cnts(input string tag);
      check({tag, " par_cnt8"}, 32'(pcnt8), 32'(sat(par_m, 8)));
      check({tag, " stp_cnt8"}, 32'(scnt8), 32'(sat(stp_m, 8)));
      check({tag, " par_cnt2"}, 32'(pcnt2), 32'(sat(par_m, 2)));
      check({tag, " stp_cnt2"}, 32'(scnt2), 32'(sat(stp_m, 2)));
   endtask

   // Non-strobe cycle: the free inputs carry noise, which must be ignored.
   task automatic drive_idle();
      bit_valid   = 1'b0;
      sampled_bit = 1'($urandom);
      frame_start = 1'($urandom);
      cnt_clr     = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         drive_idle();
      end
   endtask

   // Sends a complete frame and checks the delivery. The last stop strobe is
   // registered at the following posedge, and the result is sampled at the
   // negedge after that.
   task automatic run_frame(input int len_in, input bit pen, input bit [1:0] typ,
                            input bit sb, input logic [DW-1:0] data,
                            input bit pinj, input bit s1inj, input bit s2inj,
                            input int max_gap, input bit no_wait, input bit hold,
                            input bit clr_at_dv, input string tag);
      int            le;
      logic [DW-1:0] exp_data;
      bit            par_ok;
      bit            bits[$];
      int            dv0;
      le       = (len_in == 0 || len_in > DW) ? DW : len_in;
      exp_data = '0;
      for (int i = 0; i < le; i++) exp_data[i] = data[i];
      case (typ)
         2'd0:    par_ok = ($countones(exp_data) % 2) == 1;
         2'd1:    par_ok = ($countones(exp_data) % 2) == 0;
         2'd2:    par_ok = 1'b1;
         default: par_ok = 1'b0;
      endcase
      bits.push_back(1'b0);
      for (int i = 0; i < le; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(par_ok ^ pinj);
      bits.push_back(~s1inj);
      if (sb) bits.push_back(~s2inj);

      dv0 = dv_cnt;
      for (int i = 0; i < bits.size(); i++) begin
         if (!(i == 0 && no_wait)) @(negedge CLK);
         if (i > 0)
            repeat ($urandom_range(max_gap, 0)) begin
               drive_idle();
               @(negedge CLK);
            end
         bit_valid   = 1'b1;
         sampled_bit = bits[i];
         frame_start = (i == 0);
         cnt_clr     = 1'b0;
         if (i == 0) begin
            DATA_LEN  = LW'(len_in);
            PAR_EN    = pen;
            PAR_TYP   = typ;
            STOP_BITS = sb;
         end else begin
            // The settings are latched at the start bit, so later changes
            // must have no effect on this frame.
            DATA_LEN  = LW'($urandom);
            PAR_EN    = 1'($urandom);
            PAR_TYP   = 2'($urandom);
            STOP_BITS = 1'($urandom);
         end
      end
      @(negedge CLK);
      check({tag, " dv_count"}, 32'(dv_cnt - dv0), 32'd1);
      check({tag, " dv"},       32'(dv8), 32'd1);
      check({tag, " data"},     32'(p_data8), 32'(exp_data));
      check({tag, " par_err"},  32'(perr8), 32'(pen & pinj));
      check({tag, " stp_err"},  32'(serr8), 32'(s1inj | (sb & s2inj)));
      last_data = exp_data;
      if (pen & pinj) par_m++;
      if (s1inj | (sb & s2inj)) stp_m++;
      if (!hold) drive_idle();
      if (clr_at_dv) begin
         cnt_clr = 1'b1;
         par_m   = 0;
         stp_m   = 0;
      end
   endtask

   initial begin
      int dv0;
      sampled_bit = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
      DATA_LEN = '0; PAR_EN = 1'b0; PAR_TYP = 2'b00; STOP_BITS = 1'b0; cnt_clr = 1'b0;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst data", 32'(p_data8), 32'd0);
      check("rst dv",   32'(dv8), 32'd0);
      check("rst flags", 32'({perr8, serr8, strt8}), 32'd0);
      check_cnts("rst");
      RST = 1'b1;
      idle(2);

      // 8N1, 0xA5
      run_frame(8, 0, 2'd0, 0, 8'hA5, 0, 0, 0, 0, 0, 0, 0, "8n1");
      idle(1);
      check_cnts("8n1");

      // 8E1, 0x01. The correct even parity bit is 1, so sending 0 is an error.
      run_frame(8, 1, 2'd0, 0, 8'h01, 1, 0, 0, 0, 0, 0, 0, "8e1 bad");
      idle(1);
      check_cnts("8e1 bad");
      run_frame(8, 1, 2'd0, 0, 8'h01, 0, 0, 0, 0, 0, 0, 0, "8e1 good");
      idle(1);

      // 5 bits, mark parity, two stop bits, second stop bit is 0
      run_frame(5, 1, 2'd2, 1, 8'h1F, 0, 0, 1, 1, 0, 0, 0, "5m2");
      idle(3);
      check("hold data", 32'(p_data8), 32'h1F);
      check_cnts("5m2");

      // Saturation on the 2-bit counters, then a clear that coincides with an error
      @(negedge CLK); cnt_clr = 1'b1; par_m = 0; stp_m = 0;
      idle(1);
      for (int k = 0; k < 4; k++) begin
         run_frame(8, 0, 2'd0, 0, 8'(k), 0, 1, 0, 0, 0, 0, 0, "sat");
         idle(1);
      end
      check_cnts("sat4");
      run_frame(8, 0, 2'd0, 0, 8'h55, 0, 1, 0, 0, 0, 0, 1, "clr5");
      idle(2);
      check_cnts("clr5");

      // Randomized frames, including illegal lengths 0 and 9..15
      for (int n = 0; n < 40; n++) begin
         run_frame($urandom_range(15, 0), 1'($urandom), 2'($urandom), 1'($urandom),
                   8'($urandom), $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                   $urandom_range(3, 0) == 0, 2, 0, 0, $urandom_range(7, 0) == 0, "rand");
         idle(1 + $urandom_range(2, 0));
         check("rand hold", 32'(p_data8), 32'(last_data));
         check_cnts("rand");
      end

      // Start strobe carrying a 1: strt_err pulse, the FSM stays in IDLE
      dv0 = dv_cnt;
      @(negedge CLK);
      bit_valid = 1'b1; frame_start = 1'b1; sampled_bit = 1'b1;
      @(negedge CLK);
      check("strt pulse", 32'(strt8), 32'd1);
      drive_idle();
      @(negedge CLK);
      check("strt clear", 32'(strt8), 32'd0);
      for (int k = 0; k < 12; k++) begin
         bit_valid = 1'b1; frame_start = 1'b0; sampled_bit = 1'b1;
         @(negedge CLK);
      end
      drive_idle();
      idle(2);
      check("strt no frame", 32'(dv_cnt - dv0), 32'd0);

      // Abort after 3 data bits, then a clean 0x3C frame
      @(negedge CLK);
      bit_valid = 1'b1; frame_start = 1'b1; sampled_bit = 1'b0;
      DATA_LEN = 4'd8; PAR_EN = 1'b1; PAR_TYP = 2'b00; STOP_BITS = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         bit_valid = 1'b1; frame_start = 1'b0; sampled_bit = 1'b1;
      end
      run_frame(8, 0, 2'd0, 0, 8'h3C, 0, 0, 0, 0, 0, 0, 0, "abort");
      idle(1);

      // Back-to-back: the next start strobe arrives in the data_valid cycle
      run_frame(8, 1, 2'd1, 0, 8'hC3, 1, 0, 0, 0, 0, 1, 0, "b2b a");
      run_frame(6, 1, 2'd3, 1, 8'h2A, 0, 1, 1, 0, 1, 0, 0, "b2b b");
      idle(1);
      check_cnts("b2b");

      // Reset in the middle of a frame: everything clears, nothing is delivered
      dv0 = dv_cnt;
      @(negedge CLK);
      bit_valid = 1'b1; frame_start = 1'b1; sampled_bit = 1'b0;
      DATA_LEN = 4'd8; PAR_EN = 1'b0; STOP_BITS = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         bit_valid = 1'b1; frame_start = 1'b0; sampled_bit = 1'b1;
      end
      @(negedge CLK);
      drive_idle();
      #1 RST = 1'b0;
      #1;
      check("arst data", 32'(p_data8), 32'd0);
      check("arst flags", 32'({dv8, perr8, serr8, strt8}), 32'd0);
      par_m = 0; stp_m = 0;
      check_cnts("arst");
      @(negedge CLK);
      RST = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         bit_valid = 1'b1; frame_start = 1'b0; sampled_bit = 1'b1;
      end
      drive_idle();
      idle(3);
      check("arst no frame", 32'(dv_cnt - dv0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/frame_check.md
FRAME_CHECK -- requirements
Module: frame_check

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each saturating error counter.
REQ-003 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sampled_bit  input  1  sampled serial bit value.
REQ-006 SHALL have port bit_valid  input  1  one-cycle strobe qualifying sampled_bit.
REQ-007 SHALL have port frame_start  input  1  marks the strobed bit as a start bit; only meaningful with bit_valid=1.
REQ-008 SHALL have port DATA_LEN  input  $clog2(DATA_WIDTH+1)  data bits per frame.
REQ-009 SHALL have port PAR_EN  input  1  parity bit present.
REQ-010 SHALL have port PAR_TYP  input  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
REQ-011 SHALL have port STOP_BITS  input  1  0 = one stop bit, 1 = two stop bits.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of both error counters.
REQ-013 SHALL have port P_DATA  output  DATA_WIDTH  received data, right-aligned.
REQ-014 SHALL have port data_valid  output  1  one-cycle frame-complete pulse.
REQ-015 SHALL have port par_err  output  1  parity error for the frame, valid with data_valid.
REQ-016 SHALL have port stp_err  output  1  stop error for the frame, valid with data_valid.
REQ-017 SHALL have port strt_err  output  1  one-cycle pulse on a rejected start bit.
REQ-018 SHALL have ports par_err_cnt, stp_err_cnt  output  CNT_WIDTH  saturating error counts.

Function
REQ-019 SHALL implement FSM states IDLE, DATA, PARITY, STOP1, STOP2; only a cycle with bit_valid=1 advances the FSM.
REQ-020 SHALL, in IDLE on bit_valid&frame_start: bit=0 -> DATA, clear bit counter and running parity, latch DATA_LEN/PAR_EN/PAR_TYP/STOP_BITS; bit=1 -> pulse strt_err next cycle, stay IDLE.
REQ-021 SHALL ignore bit_valid without frame_start in IDLE.
REQ-022 SHALL treat latched DATA_LEN of 0 or >DATA_WIDTH as DATA_WIDTH.
REQ-023 SHALL, in DATA, shift bits LSB-first into a clear-at-start shadow register, XOR each into running parity; after the DATA_LEN-th bit go to PARITY if PAR_EN else STOP1.
REQ-024 SHALL, in PARITY, compute expected = running parity (even), its inverse (odd), 1 (mark), 0 (space); record error = expected XOR bit; go to STOP1.
REQ-025 SHALL, in STOP1/STOP2, record stop error if bit=0 (errors OR-accumulate across both stop bits); STOP1 -> STOP2 if STOP_BITS else complete; STOP2 -> complete.
REQ-026 SHALL, on complete, return to IDLE and in the next cycle assert data_valid for exactly one cycle with P_DATA, par_err, stp_err updated from the frame.
REQ-027 SHALL hold P_DATA, par_err, stp_err stable between completions; par_err SHALL be 0 when PAR_EN was 0.
REQ-028 SHALL, on bit_valid&frame_start in any non-IDLE state, abort the current frame (no data_valid, no counter update) and process the bit as a start bit per REQ-020.
REQ-029 SHALL increment par_err_cnt/stp_err_cnt by 1 in the data_valid cycle when the respective flag is 1, saturating at all-ones.
REQ-030 SHALL give cnt_clr priority over a simultaneous increment (counter becomes 0).
REQ-031 SHALL accept back-to-back strobes on consecutive cycles, including a new frame_start in the data_valid cycle.

Reset
REQ-032 SHALL, while RST=0, force FSM to IDLE and P_DATA, data_valid, par_err, stp_err, strt_err, both counters, shadow register, bit counter and running parity to 0, independent of CLK.
REQ-033 SHALL, on reset mid-frame, discard the frame with no data_valid after release.

Verification
REQ-034 SHALL test 8N1 frame 0,0xA5 LSB-first,1 -> data_valid one cycle after stop strobe, P_DATA=0xA5, par_err=0, stp_err=0.
REQ-035 SHALL test 8E1 data 0x01, parity bit 0 -> par_err=1, par_err_cnt=1; same frame parity bit 1 -> par_err=0.
REQ-036 SHALL test DATA_LEN=5 mark parity, STOP_BITS=1, data 0x1F, parity 1, stops 1,0 -> P_DATA=0x1F, par_err=0, stp_err=1.
REQ-037 SHALL test start strobe with sampled_bit=1 -> strt_err one-cycle pulse, FSM stays IDLE, no data_valid.
REQ-038 SHALL test frame_start after 3 data bits -> first frame dropped, second 0x3C frame delivered intact.
REQ-039 SHALL test CNT_WIDTH=2 with 4 stop errors -> stp_err_cnt=3; cnt_clr coincident with 5th error -> 0.
